// File: rtl/qspi_pkg.sv
// qspi_pkg
// Constants and types shared by the QSPI flash initiator (qspi_flash) and
// the flash responder (qspi_flash_responder): opcodes, the continuous-read
// mode byte, status-register bit positions and the responder state enum.
package qspi_pkg;

    localparam logic [7:0] OP_RELEASE_PD = 8'hAB;
    localparam logic [7:0] OP_WREN       = 8'h06;
    localparam logic [7:0] OP_WRDI       = 8'h04;
    localparam logic [7:0] OP_WRSR       = 8'h01;
    localparam logic [7:0] OP_QREAD      = 8'hEB;
    localparam logic [7:0] MODE_CONT     = 8'h20;

    // Status register layout: SR1 in [7:0], SR2 in [15:8].
    localparam int SR_WEL_BIT = 0;
    localparam int SR_QE_BIT  = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WRSR   = 3'd2,
        ST_ADDR   = 3'd3,
        ST_MODE   = 3'd4,
        ST_DUMMY  = 3'd5,
        ST_DATA   = 3'd6,
        ST_IGNORE = 3'd7
    } qspi_state_e;

    // Only mode bits [5:4] matter; 2'b10 keeps the device in continuous read.
    function automatic logic mode_is_cont(input logic [7:0] mode);
        return (mode & 8'h30) == (MODE_CONT & 8'h30);
    endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// qspi_edge_sync
// Brings the asynchronous QSPI pad signals into the clk domain through a
// SYNC_STAGES-deep flop chain and derives single-cycle edge pulses.
// Ports:
//   clk_i, rst_ni      system clock, asynchronous active-low reset
//   cs_ni, sclk_i      raw chip select (active low) and serial clock
//   io_i[3:0]          raw pad inputs {hold, wp, so, si}
//   cs_rise_o/fall_o   one-cycle pulses on synchronized cs edges
//   sclk_rise_o/fall_o one-cycle pulses on synchronized sclk edges
//   io_o[3:0]          synchronized pad inputs, aligned with the sclk pulses
module qspi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cs_ni,
    input  logic       sclk_i,
    input  logic [3:0] io_i,
    output logic       cs_rise_o,
    output logic       cs_fall_o,
    output logic       sclk_rise_o,
    output logic       sclk_fall_o,
    output logic [3:0] io_o
);

    // Bit order inside the chain: {io[3:0], sclk, cs}. cs idles high.
    localparam logic [5:0] SYNC_RST = 6'b000001;

    logic [5:0] sync_q [SYNC_STAGES];
    logic [1:0] prev_q;
    logic [5:0] last_s;

    assign last_s = sync_q[SYNC_STAGES-1];

    // Synchronizer chain plus one extra stage of cs/sclk for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            prev_q <= 2'b01;
        end else begin
            sync_q[0] <= {io_i, sclk_i, cs_ni};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= last_s[1:0];
        end
    end

    assign cs_rise_o   =  last_s[0] & ~prev_q[0];
    assign cs_fall_o   = ~last_s[0] &  prev_q[0];
    assign sclk_rise_o =  last_s[1] & ~prev_q[1];
    assign sclk_fall_o = ~last_s[1] &  prev_q[1];
    assign io_o        =  last_s[5:2];

endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
// Device side of a QSPI flash bus. Decodes release-power-down, WREN, WRDI,
// WRSR and quad-IO read (0xEB, with continuous-read mode) and serves read
// data from a byte-wide synchronous memory port. The bus is oversampled in
// the clk domain, so clk must run at least 8x faster than sclk.
// Ports:
//   clk_i, rst_ni   system clock, asynchronous active-low reset
//   cs_ni, sclk_i   chip select (active low), serial clock (mode 0)
//   io_in_i[3:0]    pad inputs {hold, wp, so, si}
//   io_out_o[3:0]   pad output values, io_oe_o[3:0] per-pin enables
//   mem_addr_o      read address, mem_rd_o one-cycle read strobe
//   mem_rdata_i     read data, valid one clk after mem_rd_o
//   qe_o            quad-enable status bit (SR2[1])
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cs_ni,
    input  logic              sclk_i,
    input  logic [3:0]        io_in_i,
    output logic [3:0]        io_out_o,
    output logic [3:0]        io_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              qe_o
);

    logic       cs_rise_s, cs_fall_s, sclk_rise_s, sclk_fall_s;
    logic [3:0] io_s;
    logic [7:0] opcode_s;
    logic [7:0] mode_s;

    qspi_state_e       state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [15:0]       shift_q, shift_d;
    logic [15:0]       sr_q, sr_d;
    logic              pd_q, pd_d;
    logic              cont_q, cont_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        io_out_q, io_out_d;
    logic [3:0]        io_oe_q, io_oe_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        pref_q, pref_d;
    logic [3:0]        lo_nib_q, lo_nib_d;
    logic              nib_lo_q, nib_lo_d;

    qspi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cs_ni       (cs_ni),
        .sclk_i      (sclk_i),
        .io_i        (io_in_i),
        .cs_rise_o   (cs_rise_s),
        .cs_fall_o   (cs_fall_s),
        .sclk_rise_o (sclk_rise_s),
        .sclk_fall_o (sclk_fall_s),
        .io_o        (io_s)
    );

    // Byte completed by the bit / nibble arriving on this rising edge.
    assign opcode_s = {shift_q[6:0], io_s[0]};
    assign mode_s   = {shift_q[3:0], io_s};

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            shift_q   <= 16'h0000;
            sr_q      <= 16'h0000;
            pd_q      <= 1'b1;
            cont_q    <= 1'b0;
            addr_q    <= '0;
            io_out_q  <= 4'h0;
            io_oe_q   <= 4'h0;
            mem_rd_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            pref_q    <= 8'h00;
            lo_nib_q  <= 4'h0;
            nib_lo_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            sr_q      <= sr_d;
            pd_q      <= pd_d;
            cont_q    <= cont_d;
            addr_q    <= addr_d;
            io_out_q  <= io_out_d;
            io_oe_q   <= io_oe_d;
            mem_rd_q  <= mem_rd_d;
            rd_pend_q <= rd_pend_d;
            pref_q    <= pref_d;
            lo_nib_q  <= lo_nib_d;
            nib_lo_q  <= nib_lo_d;
        end
    end

    // Next-state and datapath decisions; cs deassertion overrides every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        sr_d      = sr_q;
        pd_d      = pd_q;
        cont_d    = cont_q;
        addr_d    = addr_q;
        io_out_d  = io_out_q;
        io_oe_d   = io_oe_q;
        mem_rd_d  = 1'b0;
        rd_pend_d = mem_rd_q;
        lo_nib_d  = lo_nib_q;
        nib_lo_d  = nib_lo_q;
        pref_d    = rd_pend_q ? mem_rdata_i : pref_q;

        if (cs_rise_s) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            io_oe_d = 4'h0;
            // WRSR commits only on a complete SR1+SR2 with WEL set; WEL drops either way.
            if (state_q == ST_WRSR) begin
                if ((cnt_q == 5'd16) && sr_q[SR_WEL_BIT]) begin
                    sr_d = {shift_q[7:0], shift_q[15:9], 1'b0};
                end else begin
                    sr_d = {sr_q[15:1], 1'b0};
                end
            end else begin
                sr_d = sr_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    io_oe_d = 4'h0;
                    if (cs_fall_s) begin
                        cnt_d   = 5'd0;
                        state_d = cont_q ? ST_ADDR : ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        shift_d = {shift_q[14:0], io_s[0]};
                        if (cnt_q == 5'd7) begin
                            cnt_d   = 5'd0;
                            state_d = ST_IGNORE;
                            if (pd_q) begin
                                pd_d = (opcode_s != OP_RELEASE_PD);
                            end else begin
                                case (opcode_s)
                                    OP_WREN:  sr_d[SR_WEL_BIT] = 1'b1;
                                    OP_WRDI:  sr_d[SR_WEL_BIT] = 1'b0;
                                    OP_WRSR:  state_d = ST_WRSR;
                                    OP_QREAD: state_d = sr_q[SR_QE_BIT] ? ST_ADDR : ST_IGNORE;
                                    default:  state_d = ST_IGNORE;
                                endcase
                            end
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_WRSR: begin
                    // Bits beyond the two status bytes are ignored.
                    if (sclk_rise_s && (cnt_q != 5'd16)) begin
                        shift_d = {shift_q[14:0], io_s[0]};
                        cnt_d   = cnt_q + 5'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        addr_d = {addr_q[ADDR_W-5:0], io_s};
                        if (cnt_q == 5'd5) begin
                            cnt_d   = 5'd0;
                            state_d = ST_MODE;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_MODE: begin
                    if (sclk_rise_s) begin
                        shift_d = {shift_q[11:0], io_s};
                        if (cnt_q == 5'd1) begin
                            cont_d   = mode_is_cont(mode_s);
                            cnt_d    = 5'd0;
                            state_d  = ST_DUMMY;
                            // First byte is fetched during the dummy clocks.
                            mem_rd_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DUMMY: begin
                    io_oe_d = 4'h0;
                    if (sclk_rise_s) begin
                        if (cnt_q == 5'd3) begin
                            cnt_d    = 5'd0;
                            state_d  = ST_DATA;
                            nib_lo_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DATA: begin
                    if (sclk_fall_s) begin
                        io_oe_d = 4'hF;
                        if (!nib_lo_q) begin
                            // Latch the low nibble so the prefetch register is free for the next byte.
                            io_out_d = pref_q[7:4];
                            lo_nib_d = pref_q[3:0];
                            nib_lo_d = 1'b1;
                        end else begin
                            io_out_d = lo_nib_q;
                            nib_lo_d = 1'b0;
                            addr_d   = addr_q + ADDR_W'(1);
                            mem_rd_d = 1'b1;
                        end
                    end else begin
                        io_out_d = io_out_q;
                    end
                end
                ST_IGNORE: begin
                    io_oe_d = 4'h0;
                end
                default: begin
                    state_d = ST_IDLE;
                    io_oe_d = 4'h0;
                end
            endcase
        end
    end

    assign io_out_o   = io_out_q;
    assign io_oe_o    = io_oe_q;
    assign mem_addr_o = addr_q;
    assign mem_rd_o   = mem_rd_q;
    assign qe_o       = sr_q[SR_QE_BIT];

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Testbench for qspi_flash_responder: drives the QSPI bus as an initiator,
// models the memory port, and compares against a transaction-level model of
// the status register, power-down flag and continuous-read mode.
module tb_qspi_flash_responder;

    localparam int HALF = 8;  // clk cycles per sclk half period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        sclk;
    logic [3:0]  io_in;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        qe;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_pulses = 0;

    // Reference model state.
    logic [15:0] m_sr;
    logic        m_pd;
    logic        m_cont;

    logic [7:0] mem_ovr [logic [23:0]];

    qspi_flash_responder #(
        .ADDR_W      (24),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cs_ni       (cs_n),
        .sclk_i      (sclk),
        .io_in_i     (io_in),
        .io_out_o    (io_out),
        .io_oe_o     (io_oe),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_rdata_i (mem_rdata),
        .qe_o        (qe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Synchronous memory: data one clk after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_val(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_rd) rd_pulses <= rd_pulses + 1;
    end

    task automatic sclk_cycle(input logic [3:0] drive, output logic [3:0] obs_out, output logic [3:0] obs_oe);
        io_in = drive;
        repeat (HALF) @(negedge clk);
        obs_out = io_out;
        obs_oe  = io_oe;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [3:0] oe_or);
        logic [3:0] o, e;
        oe_or = 4'h0;
        for (int i = 7; i >= 0; i--) begin
            sclk_cycle({3'b111, b[i]}, o, e);
            oe_or |= e;
        end
    endtask

    task automatic cmd_only(input logic [7:0] op);
        logic [3:0] e;
        cs_begin();
        send_byte(op, e);
        cs_end();
        if (m_pd) begin
            if (op == 8'hAB) m_pd = 1'b0;
        end else if (op == 8'h06) begin
            m_sr[0] = 1'b1;
        end else if (op == 8'h04) begin
            m_sr[0] = 1'b0;
        end
        n_checks++;
        if (e !== 4'h0) $display("FAIL cmd_oe op=%h: got %h want 0", op, e);
        else n_pass++;
        n_checks++;
        if (qe !== m_sr[9]) $display("FAIL cmd_qe op=%h: got %b want %b", op, qe, m_sr[9]);
        else n_pass++;
    endtask

    task automatic wrsr(input logic [7:0] b1, input logic [7:0] b2);
        logic [3:0] e, acc;
        cs_begin();
        send_byte(8'h01, acc);
        send_byte(b1, e);
        acc |= e;
        send_byte(b2, e);
        acc |= e;
        cs_end();
        if (!m_pd) begin
            if (m_sr[0]) m_sr = {b2, b1};
            m_sr[0] = 1'b0;
        end
        n_checks++;
        if (acc !== 4'h0) $display("FAIL wrsr_oe: got %h want 0", acc);
        else n_pass++;
        n_checks++;
        if (qe !== m_sr[9]) $display("FAIL wrsr_qe %h %h: got %b want %b", b1, b2, qe, m_sr[9]);
        else n_pass++;
    endtask

    task automatic quad_read(input logic [23:0] addr, input logic [7:0] mode, input int nbytes, input string tag);
        logic [3:0] o, e, acc, exp_nib;
        logic [7:0] b;
        logic       served;
        int         rd0, exp_rd;
        served = m_cont || (!m_pd && m_sr[9]);
        rd0 = rd_pulses;
        acc = 4'h0;
        cs_begin();
        if (!m_cont) begin
            send_byte(8'hEB, e);
            acc |= e;
        end
        for (int k = 0; k < 6; k++) begin
            sclk_cycle(addr[23-4*k -: 4], o, e);
            acc |= e;
        end
        sclk_cycle(mode[7:4], o, e);
        acc |= e;
        sclk_cycle(mode[3:0], o, e);
        acc |= e;
        for (int k = 0; k < 4; k++) begin
            sclk_cycle(4'h0, o, e);
            acc |= e;
        end
        n_checks++;
        if (acc !== 4'h0) $display("FAIL %s hdr_oe: got %h want 0", tag, acc);
        else n_pass++;
        for (int i = 0; i < 2 * nbytes; i++) begin
            sclk_cycle(4'h0, o, e);
            b = mem_val(addr + 24'(i / 2));
            exp_nib = (i % 2 == 0) ? b[7:4] : b[3:0];
            n_checks++;
            if (served) begin
                if (e !== 4'hF || o !== exp_nib)
                    $display("FAIL %s nib%0d: got oe=%h out=%h want oe=f out=%h", tag, i, e, o, exp_nib);
                else n_pass++;
            end else begin
                if (e !== 4'h0) $display("FAIL %s nib%0d: got oe=%h want 0", tag, i, e);
                else n_pass++;
            end
        end
        cs_end();
        n_checks++;
        if (io_oe !== 4'h0) $display("FAIL %s oe_after_cs: got %h want 0", tag, io_oe);
        else n_pass++;
        exp_rd = served ? nbytes + 1 : 0;
        n_checks++;
        if ((rd_pulses - rd0) != exp_rd) $display("FAIL %s mem_rd_count: got %0d want %0d", tag, rd_pulses - rd0, exp_rd);
        else n_pass++;
        if (served) m_cont = ((mode & 8'h30) == 8'h20);
    endtask

    task automatic test_reset();
        n_checks++;
        if (io_oe !== 4'h0) $display("FAIL reset_oe: got %h want 0", io_oe);
        else n_pass++;
        n_checks++;
        if (qe !== 1'b0) $display("FAIL reset_qe: got %b want 0", qe);
        else n_pass++;
        n_checks++;
        if (mem_rd !== 1'b0 || rd_pulses != 0) $display("FAIL reset_mem_rd: got %b/%0d want 0/0", mem_rd, rd_pulses);
        else n_pass++;
    endtask

    task automatic test_wakeup_status();
        cmd_only(8'h06);        // ignored while powered down
        wrsr(8'h80, 8'h02);     // ignored while powered down
        cmd_only(8'hAB);
        cmd_only(8'h06);
        wrsr(8'h80, 8'h02);     // QE set
        cmd_only(8'h04);
        wrsr(8'h00, 8'h00);     // WEL clear -> no effect
    endtask

    task automatic test_quad_read();
        mem_ovr[24'h8F428F] = 8'h02;
        mem_ovr[24'h8F4290] = 8'h01;
        mem_ovr[24'h8F4291] = 8'hFF;
        mem_ovr[24'h8F4292] = 8'h7A;
        quad_read(24'h8F428F, 8'h20, 4, "quad");
    endtask

    task automatic test_continuous();
        quad_read(24'h70BD70, 8'h20, 2, "cont1");
        quad_read(24'h70BD72, 8'h00, 2, "cont_exit");
        cmd_only(8'h06);
        wrsr(8'h00, 8'h00);     // proves 0x06 was decoded as an opcode
        cmd_only(8'h06);
        wrsr(8'h00, 8'h02);
    endtask

    task automatic test_random_reads();
        logic [23:0] a;
        logic [7:0]  mode;
        int          n;
        for (int t = 0; t < 6; t++) begin
            a    = 24'($urandom);
            mode = 8'($urandom_range(0, 255));
            n    = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) mem_ovr[a + 24'(j)] = 8'($urandom);
            quad_read(a, mode, n, "rand");
        end
        quad_read(24'($urandom), 8'h00, 1, "rand_exit");
    endtask

    task automatic test_qe_off();
        cmd_only(8'h06);
        wrsr(8'h00, 8'h00);     // QE cleared
        quad_read(24'h123456, 8'h20, 2, "qe_off");
        wrsr(8'h00, 8'h02);     // no WREN -> unchanged
        cmd_only(8'h06);
        wrsr(8'h00, 8'h02);
    endtask

    task automatic test_abort_wrap();
        logic [3:0] o, e;
        cs_begin();
        send_byte(8'hEB, e);
        for (int k = 0; k < 3; k++) sclk_cycle(4'hA, o, e);
        cs_end();
        n_checks++;
        if (io_oe !== 4'h0) $display("FAIL abort_oe: got %h want 0", io_oe);
        else n_pass++;
        mem_ovr[24'hFFFFFF] = 8'($urandom);
        mem_ovr[24'h000000] = 8'($urandom);
        quad_read(24'hFFFFFF, 8'hFF, 2, "wrap");
    endtask

    task automatic test_reset_mid_data();
        logic [3:0]  o, e;
        logic [23:0] a;
        logic [7:0]  b;
        a = 24'h00ABCD;
        cs_begin();
        send_byte(8'hEB, e);
        for (int k = 0; k < 6; k++) sclk_cycle(a[23-4*k -: 4], o, e);
        sclk_cycle(4'h2, o, e);
        sclk_cycle(4'h0, o, e);
        for (int k = 0; k < 4; k++) sclk_cycle(4'h0, o, e);
        for (int k = 0; k < 3; k++) sclk_cycle(4'h0, o, e);
        b = mem_val(a + 24'd1);
        n_checks++;
        if (e !== 4'hF || o !== b[7:4]) $display("FAIL mid_data: got oe=%h out=%h want oe=f out=%h", e, o, b[7:4]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (io_oe !== 4'h0) $display("FAIL rst_oe: got %h want 0", io_oe);
        else n_pass++;
        n_checks++;
        if (qe !== 1'b0) $display("FAIL rst_qe: got %b want 0", qe);
        else n_pass++;
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        m_sr   = 16'h0000;
        m_pd   = 1'b1;
        m_cont = 1'b0;
        quad_read(24'h000010, 8'h20, 1, "after_rst");  // powered down: not served
        cmd_only(8'h06);
        wrsr(8'h00, 8'h02);
    endtask

    initial begin
        rst_n  = 1'b0;
        cs_n   = 1'b1;
        sclk   = 1'b0;
        io_in  = 4'hF;
        m_sr   = 16'h0000;
        m_pd   = 1'b1;
        m_cont = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);

        test_reset();
        test_wakeup_status();
        test_quad_read();
        test_continuous();
        test_random_reads();
        test_qe_off();
        test_abort_wrap();
        test_reset_mid_data();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI flash responder: the device end of the bus driven by `qspi_flash`. Decodes wake-up, write-enable/disable, write-status and quad-IO continuous read (0xEB) commands, serves data from a byte-wide synchronous memory port, and replaces the external flash in simulation and in flash-less FPGA builds. All bus sampling is done in the `clk` domain by oversampling `sclk`/`cs`.

## Interface
- `ADDR_W`, 24, memory address width; the read address wraps modulo 2^ADDR_W.
- `SYNC_STAGES`, 2, synchronizer depth on `cs`, `sclk` and `io_in`.
- `clk`  in  1  system clock; must be at least 8× the `sclk` frequency.
- `rst`  in  1  reset, asynchronous and active-low.
- `cs`  in  1  chip select, active low.
- `sclk`  in  1  serial clock from the initiator (mode 0).
- `io_in`  in  4  pad inputs {hold, wp, so, si}.
- `io_out`  out  4  pad output values, same bit order.
- `io_oe`  out  4  per-pin output enable; 0 means high-Z.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_rdata`  in  8  read data, valid exactly 1 `clk` after `mem_rd`.
- `qe`  out  1  quad-enable status bit (SR2[1]), for debug.

## Operation
- Status register is 16 bits. WEL = SR1[0], QE = SR2[1]. Power-down flag `pd`. Reset values: SR = 0, `pd` = 1, continuous mode = 0.
- Rising-`sclk` edge (detected after sync) samples inputs. Falling-`sclk` edge shifts out the next output bit or nibble. Single-bit phases sample `io_in[0]` MSB first. Quad phases sample `io_in[3:0]` high nibble first.
- State machine:
  - IDLE: wait for `cs` low.
  - `cs` low goes to ADDR if continuous mode = 1, otherwise to CMD.
- CMD collects 8 bits. With `pd` = 1, only 0xAB is accepted and it clears `pd`. Otherwise:
  - 0x06 sets WEL.
  - 0x04 clears WEL.
  - 0x01 goes to WRSR.
  - 0xEB goes to ADDR if QE = 1, otherwise to IGNORE.
  - Any other opcode goes to IGNORE.
- WRSR collects SR1 then SR2, one bit per edge. SR is written only if WEL was set, and only when `cs` rises after both full bytes. WEL is cleared either way.
- ADDR collects 6 nibbles, then goes to MODE.
- MODE collects 2 nibbles. Continuous mode is set iff mode[5:4] = 2'b10 (0x20 qualifies), otherwise cleared. Then goes to DUMMY.
- DUMMY lasts 4 `sclk` cycles with `io_oe` = 0. `mem_rd` for the first byte issues on entry.
- DATA drives a nibble per falling edge, high nibble first, with `io_oe` = 4'hF. After each low nibble starts driving, the address increments and the next `mem_rd` issues, so one byte is always prefetched.
- IGNORE: stays until `cs` rises, outputs high-Z.
- `cs` rising in any state returns to IDLE and sets `io_oe` = 0 within 1 `clk` of the synced edge. Partial commands and partial status bytes are discarded. Continuous mode persists.

## Timing
- Input-to-decision latency is SYNC_STAGES + 1 `clk`. A nibble is valid on the pins at most SYNC_STAGES + 2 `clk` after the falling `sclk` edge. This is why `clk` ≥ 8× `sclk`.
- `io_oe` stays 0 in all single-bit phases; the initiator owns `si`.
- Memory port: `mem_addr` is stable while `mem_rd` is high. `mem_rdata` is captured in the next cycle into the prefetch register. There is no backpressure.
- Address wrap: 2^ADDR_W − 1 is followed by 0.
- Reset mid-transfer: immediate return to all reset values, outputs high-Z.

## Structure
- Package `qspi_pkg` holds the opcode constants (0xAB, 0x06, 0x04, 0x01, 0xEB), the continuous-mode byte 0x20 and the state enum. These are shared with `qspi_flash`.
- Sub-module `qspi_edge_sync` provides the synchronizer plus rise/fall pulses for `cs` and `sclk`, and the synchronized `io_in`.

## Test plan
- Out of reset, send 0xAB then 0x06, then 0x01 with 0x80 and 0x02, then 0x04 → `qe` = 1, WEL = 0.
- With QE = 1, send 0xEB, address 0x8F428F, mode 0x20, then 4 dummy clocks → `io_oe` = 0 during dummy. Data nibbles equal mem[0x8F428F..] (prefill 0x02, 0x01, 0xFF, 0x7A), high nibble first.
- Next `cs`-low: address 0x70BD70 with no opcode → served from that address; continuous mode retained.
- Mode byte 0x00 → current read served. The following `cs`-low expects an opcode: 0x06 sets WEL.
- 0xEB with QE = 0 → `io_oe` stays 0 and `mem_rd` never pulses. Also 0x01 without prior 0x06 → SR unchanged.
- `cs` raised after 3 address nibbles, then a full 0xEB read at 0xFFFFFF → bytes mem[0xFFFFFF] then mem[0x000000]. `rst` asserted mid-DATA → `io_oe` = 0 and `pd` = 1.
